wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the number of bus cycles to wait for wb_ack_i before aborting (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port cmd_valid  input  1  command request from the local side.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr  input  32  target byte address.
REQ-008 SHALL have port cmd_dat  input  32  write data.
REQ-009 SHALL have port cmd_sel  input  4  byte selects.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-012 SHALL have port rsp_dat  output  32  read data; 0 for writes and timeouts.
REQ-013 SHALL have port rsp_err  output  1  1 = timeout, no ack received.
REQ-014 SHALL have Wishbone master ports wb_adr_o out 32, wb_dat_o out 32, wb_dat_i in 32, wb_we_o out 1, wb_sel_o out 4, wb_stb_o out 1, wb_cyc_o out 1, wb_ack_i in 1.

Function
REQ-015 SHALL implement the FSM states IDLE, BUS and RESP, all registered.
REQ-016 SHALL assert cmd_ready only in IDLE; it is 0 in BUS, in RESP and during reset.
REQ-017 On an accepted command in IDLE (cycle N), SHALL latch we/adr/dat/sel, clear the wait counter, and enter BUS.
REQ-018 In BUS, SHALL drive wb_cyc_o = wb_stb_o = 1 starting at cycle N+1, with wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o equal to the latched values and stable for the whole of BUS.
REQ-019 In BUS, SHALL increment the wait counter once per cycle in which wb_ack_i = 0.
REQ-020 On wb_ack_i = 1 in BUS, SHALL clear cyc/stb at the next edge and enter RESP. rsp_err = 0. rsp_dat = wb_dat_i sampled in the ack cycle if the command was a read, otherwise 0.
REQ-021 On counter = TIMEOUT-1 with wb_ack_i = 0, SHALL clear cyc/stb at the next edge and enter RESP with rsp_err = 1 and rsp_dat = 0.
REQ-022 If ack arrives in the same cycle the timeout would fire, the ack SHALL win and rsp_err = 0.
REQ-023 SHALL never hold cyc/stb high for more than TIMEOUT consecutive cycles per command.
REQ-024 In RESP, SHALL hold rsp_valid = 1 with rsp_dat/rsp_err stable until rsp_ready = 1, then enter IDLE at the next edge.
REQ-025 A new command SHALL NOT be accepted before that IDLE cycle (minimum one idle cycle between bus cycles).
REQ-026 SHALL ignore wb_ack_i outside BUS, with no state or output change.
REQ-027 SHALL ignore cmd_* inputs outside IDLE; changes during BUS do not alter bus outputs.
REQ-028 When not in BUS, wb_cyc_o and wb_stb_o SHALL be 0; adr/dat/we/sel hold the last latched values.
REQ-029 Latency with a registered-ack slave SHALL be: accept at N, stb at N+1, ack at N+2, rsp_valid at N+3.

Reset
REQ-030 While reset = 1 at a rising edge, SHALL enter IDLE with cmd_ready = 0, and thereafter 1.
REQ-031 Reset SHALL set all wb_* outputs, rsp_valid, rsp_dat, rsp_err and the counter to 0.
REQ-032 Reset asserted in BUS or RESP SHALL drop cyc/stb and rsp_valid at that edge and discard the pending command; no response is issued.

Verification
REQ-033 Read against a registered-ack slave returning 0x0000_00A5 at adr 0x48 -> stb high exactly 2 cycles; rsp_valid at N+3 with rsp_dat = 0x0000_00A5, rsp_err = 0.
REQ-034 Write adr 0x44, dat 0x0000_003C, sel 0xF -> wb_we_o = 1 and wb_dat_o = 0x3C throughout BUS; response rsp_dat = 0, rsp_err = 0.
REQ-035 Slave never acks, TIMEOUT = 16 -> cyc/stb high exactly 16 cycles; rsp_err = 1, rsp_dat = 0.
REQ-036 Ack on the 16th stb cycle (TIMEOUT = 16) -> rsp_err = 0 with the read data.
REQ-037 rsp_ready held low 5 cycles -> rsp_valid and data stable for 5 cycles; cmd_ready = 0 throughout; cmd_valid pulses ignored.
REQ-038 Reset asserted on the 2nd BUS cycle -> cyc/stb = 0 at the next edge, no rsp_valid, cmd_ready = 1 one cycle after reset deasserts.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Purpose : bundles the local command/response handshake and the Wishbone
//           master signals of wb_cmd_master into one interface.
// Ports   : master modport = DUT view (drives cmd_ready, rsp_*, wb_*_o);
//           slave modport  = environment view (drives cmd_*, rsp_ready, wb_*_i).
interface wb_cmd_master_if;
  // local command side
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  // local response side
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  // Wishbone master side
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic        wb_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wb_dat_i, wb_ack_i,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, rsp_ready, wb_dat_i, wb_ack_i,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
           wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Purpose : turns one local command into one single-beat Wishbone cycle and
//           returns read data or a timeout error as a held response.
// Latency : accept at N, cyc/stb from N+1, rsp_valid one cycle after ack/timeout.
// Backpr. : cmd_ready only in IDLE; response held until rsp_ready; one idle
//           cycle always separates bus cycles.
// Ports   : clk, reset (sync, active-high), bus (wb_cmd_master_if.master):
//           cmd_* request, rsp_* response, wb_* Wishbone master.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 16   // wait cycles for ack, 1..255
) (
  input  logic             clk,
  input  logic             reset,
  wb_cmd_master_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_dat_q;
  logic        rsp_err_q;
  logic [31:0] wb_adr_q;
  logic [31:0] wb_dat_q;
  logic        wb_we_q;
  logic [3:0]  wb_sel_q;
  logic        wb_cyc_q;

  logic        accept_d;

  // cmd_ready_q is only ever set while in IDLE, so this implies IDLE
  assign accept_d = bus.cmd_valid & cmd_ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_sel_q    <= '0;
      wb_cyc_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // first IDLE cycle after reset keeps cmd_ready low, then raises it
          cmd_ready_q <= 1'b1;
          if (accept_d) begin
            wb_we_q     <= bus.cmd_we;
            wb_adr_q    <= bus.cmd_adr;
            wb_dat_q    <= bus.cmd_dat;
            wb_sel_q    <= bus.cmd_sel;
            wait_cnt_q  <= '0;
            wb_cyc_q    <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= BUS;
          end
        end
        BUS: begin
          if (bus.wb_ack_i) begin
            // ack beats a timeout landing in the same cycle
            wb_cyc_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= wb_we_q ? 32'd0 : bus.wb_dat_i;
            state_q     <= RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
            if (wait_cnt_q == TO_LAST) begin
              wb_cyc_q    <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_dat_q   <= '0;
              state_q     <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          wb_cyc_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.wb_adr_o  = wb_adr_q;
  assign bus.wb_dat_o  = wb_dat_q;
  assign bus.wb_we_o   = wb_we_q;
  assign bus.wb_sel_o  = wb_sel_q;
  // single-beat master: stb and cyc are always the same register
  assign bus.wb_cyc_o  = wb_cyc_q;
  assign bus.wb_stb_o  = wb_cyc_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed vector table, reset corner sequences and
// randomized commands against a transaction-level reference model.
module tb_wb_cmd_master;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_cmd_master_if bus();

  wb_cmd_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;

  // Slave model: acks in the ack_at-th stb cycle (1-based), 0 = never acks.
  int          ack_at      = 0;
  logic        ack_force   = 1'b0;
  logic [31:0] slave_rdata = '0;
  int          stb_seen    = 0;

  always @(posedge clk) begin
    if (bus.wb_stb_o) stb_seen <= stb_seen + 1;
    else              stb_seen <= 0;
  end

  assign bus.wb_ack_i = ack_force | (bus.wb_stb_o && ack_at != 0 && stb_seen == ack_at - 1);
  assign bus.wb_dat_i = slave_rdata;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_at;
    int          rdy_dly;
    logic [31:0] rdata;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_stb;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level model: how many stb cycles, error flag, returned data.
  function automatic vec_t model(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input int a_at, input int rdly,
                                 input logic [31:0] rdata);
    vec_t v;
    logic acked;
    acked     = (a_at >= 1) && (a_at <= TIMEOUT);
    v.we      = we;
    v.adr     = adr;
    v.dat     = dat;
    v.sel     = sel;
    v.ack_at  = a_at;
    v.rdy_dly = rdly;
    v.rdata   = rdata;
    v.exp_err = !acked;
    v.exp_stb = acked ? a_at : TIMEOUT;
    v.exp_dat = (!acked || we) ? 32'd0 : rdata;
    return v;
  endfunction

  task automatic run_cmd(input vec_t v);
    int   lat, stb_cnt, waitc;
    logic bad_bus, bad_rdy, bad_hold;
    waitc = 0;
    while (bus.cmd_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    if (bus.cmd_ready !== 1'b1) return;
    ack_at        = v.ack_at;
    slave_rdata   = v.rdata;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = v.we;
    bus.cmd_adr   = v.adr;
    bus.cmd_dat   = v.dat;
    bus.cmd_sel   = v.sel;
    @(negedge clk);
    // scramble command inputs: the latched bus fields must not follow them
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = ~v.we;
    bus.cmd_adr   = $urandom;
    bus.cmd_dat   = $urandom;
    bus.cmd_sel   = 4'($urandom);
    lat = 1; stb_cnt = 0; bad_bus = 1'b0; bad_rdy = 1'b0;
    while (bus.rsp_valid !== 1'b1 && lat < 300) begin
      if (bus.wb_cyc_o === 1'b1) begin
        stb_cnt++;
        if (bus.wb_stb_o !== 1'b1 || bus.wb_adr_o !== v.adr || bus.wb_dat_o !== v.dat ||
            bus.wb_we_o !== v.we || bus.wb_sel_o !== v.sel) bad_bus = 1'b1;
      end else if (bus.wb_stb_o !== 1'b0) bad_bus = 1'b1;
      if (bus.cmd_ready !== 1'b0) bad_rdy = 1'b1;
      bus.cmd_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) bad_bus = 1'b1;
    chk("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
    chk("stb_cycles", 32'(stb_cnt), 32'(v.exp_stb));
    chk("rsp_latency", 32'(lat), 32'(v.exp_stb + 1));
    chk("rsp_dat", bus.rsp_dat, v.exp_dat);
    chk("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    chk("bus_stable", 32'(bad_bus), 32'd0);
    chk("cmd_ready_busy", 32'(bad_rdy), 32'd0);
    bad_hold = 1'b0;
    for (int i = 0; i < v.rdy_dly; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      ack_force     = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_dat !== v.exp_dat || bus.rsp_err !== v.exp_err ||
          bus.cmd_ready !== 1'b0 || bus.wb_cyc_o !== 1'b0) bad_hold = 1'b1;
    end
    chk("rsp_hold", 32'(bad_hold), 32'd0);
    ack_force     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
    chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("idle_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("idle_adr_hold", bus.wb_adr_o, v.adr);
    chk("idle_we_hold", 32'(bus.wb_we_o), 32'(v.we));
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;

    //                we    adr     dat            sel  ack rdy rdata          exp_dat        err  stb
    tbl[0] = '{1'b0, 32'h48, 32'h0,        4'hF,  2, 0, 32'h0000_00A5, 32'h0000_00A5, 1'b0,  2};
    tbl[1] = '{1'b1, 32'h44, 32'h0000_003C, 4'hF,  2, 0, 32'h1234_5678, 32'h0,        1'b0,  2};
    tbl[2] = '{1'b0, 32'h80, 32'h0,        4'hF,  0, 1, 32'hFFFF_FFFF, 32'h0,        1'b1, 16};
    tbl[3] = '{1'b0, 32'h84, 32'h0,        4'h3, 16, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 16};
    tbl[4] = '{1'b0, 32'h88, 32'h0,        4'hF, 17, 0, 32'hCAFE_F00D, 32'h0,        1'b1, 16};
    tbl[5] = '{1'b0, 32'h8C, 32'h0,        4'h1,  1, 5, 32'h5A5A_0001, 32'h5A5A_0001, 1'b0,  1};
    tbl[6] = '{1'b1, 32'h90, 32'hA0A0_0B0B, 4'hC,  0, 2, 32'h7777_7777, 32'h0,        1'b1, 16};

    // reset state, sampled while reset is still asserted
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_dat", bus.rsp_dat, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_cyc_stb", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    chk("rst_wb_adr", bus.wb_adr_o, 32'd0);
    chk("rst_wb_dat", bus.wb_dat_o, 32'd0);
    chk("rst_we_sel", {27'd0, bus.wb_we_o, bus.wb_sel_o}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);

    // stray ack while idle must change nothing
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    chk("idle_ack_ready", 32'(bus.cmd_ready), 32'd1);
    chk("idle_ack_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("idle_ack_cyc", 32'(bus.wb_cyc_o), 32'd0);

    for (int i = 0; i < 7; i++) run_cmd(tbl[i]);

    // reset on the second bus cycle: command dropped, no response
    ack_at        = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_adr   = 32'h100;
    bus.cmd_sel   = 4'hF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_cyc", 32'(bus.wb_cyc_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("bus_rst_cyc_stb", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    chk("bus_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("bus_rst_ready", 32'(bus.cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("bus_rst_ready_after", 32'(bus.cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("bus_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);

    // randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      run_cmd(model(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(0, TIMEOUT + 4)), int'($urandom_range(0, 3)), $urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
